// File: rtl/class_sel_pkg.sv
`default_nettype none
// =============================================================================
// Module   : class_sel_pkg
// Brief    : Shared FSM states, score floor and index-width helper for the
//            top-2 class selector.
// Revision : 1.0
// =============================================================================
package class_sel_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MARK   = 3'd1,
        S_PASS1  = 3'd2,
        S_DRAIN1 = 3'd3,
        S_REWIND = 3'd4,
        S_PASS2  = 3'd5,
        S_DRAIN2 = 3'd6,
        S_DONE   = 3'd7
    } state_e;

    // Left-aligned most-negative value; take the top SCORE_W bits for any width.
    localparam logic [63:0] SCORE_MIN = {1'b1, 63'd0};

    function automatic int unsigned idx_width(input int unsigned max_classes);
        return (max_classes > 1) ? $clog2(max_classes) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/class_sel_if.sv
`default_nettype none
// =============================================================================
// Module   : class_sel_if
// Brief    : FIFO-side and result-side signal bundle of the top-2 selector.
// Revision : 1.0
// =============================================================================
interface class_sel_if
    import class_sel_pkg::*;
#(
    parameter int unsigned SCORE_W = 16,
    parameter int unsigned IDX_W   = idx_width(1000)
);
    logic               i_start;
    logic [15:0]        i_num_classes;
    logic [SCORE_W-1:0] i_front;
    logic               i_empty;
    logic               o_pop;
    logic               o_mark_read_rst;
    logic               o_read_rst;
    logic               o_flush;
    logic               o_busy;
    logic               o_done;
    logic [IDX_W-1:0]   o_top1_idx;
    logic [SCORE_W-1:0] o_top1_score;
    logic [IDX_W-1:0]   o_top2_idx;
    logic [SCORE_W-1:0] o_top2_score;
    logic               o_top2_vld;

    modport master (
        output i_start, i_num_classes, i_front, i_empty,
        input  o_pop, o_mark_read_rst, o_read_rst, o_flush, o_busy, o_done,
        input  o_top1_idx, o_top1_score, o_top2_idx, o_top2_score, o_top2_vld
    );

    modport slave (
        input  i_start, i_num_classes, i_front, i_empty,
        output o_pop, o_mark_read_rst, o_read_rst, o_flush, o_busy, o_done,
        output o_top1_idx, o_top1_score, o_top2_idx, o_top2_score, o_top2_vld
    );
endinterface
`default_nettype wire

// File: rtl/class_top2_select_argmax.sv
`default_nettype none
// =============================================================================
// Module   : argmax_scan
// Brief    : Streaming signed max tracker with optional single-index exclusion.
// Revision : 1.0
// =============================================================================
module argmax_scan
    import class_sel_pkg::*;
#(
    parameter int unsigned SCORE_W = 16,
    parameter int unsigned IDX_W   = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear_i,
    input  logic                      vld_i,
    input  logic [IDX_W-1:0]          idx_i,
    input  logic signed [SCORE_W-1:0] score_i,
    input  logic                      exclude_en_i,
    input  logic [IDX_W-1:0]          exclude_idx_i,
    output logic [IDX_W-1:0]          best_idx_o,
    output logic signed [SCORE_W-1:0] best_score_o
);
    localparam logic signed [SCORE_W-1:0] c_score_min = SCORE_MIN[63 -: SCORE_W];

    logic                      have_q, have_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [SCORE_W-1:0] score_q, score_d;
    logic                      w_take;

    // The first accepted element always loads, so a frame of all-minimum scores still reports index 0.
    always_comb begin
        w_take  = vld_i && !(exclude_en_i && (idx_i == exclude_idx_i))
                  && (!have_q || (score_i > score_q));
        have_d  = have_q;
        idx_d   = idx_q;
        score_d = score_q;
        if (clear_i) begin
            have_d  = 1'b0;
            idx_d   = '0;
            score_d = c_score_min;
        end else if (w_take) begin
            have_d  = 1'b1;
            idx_d   = idx_i;
            score_d = score_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_q  <= 1'b0;
            idx_q   <= '0;
            score_q <= c_score_min;
        end else begin
            have_q  <= have_d;
            idx_q   <= idx_d;
            score_q <= score_d;
        end
    end

    assign best_idx_o   = idx_q;
    assign best_score_o = score_q;
endmodule
`default_nettype wire

// File: rtl/class_top2_select.sv
`default_nettype none
// =============================================================================
// Module   : class_top2_select
// Brief    : Two-pass top-1 / top-2 selector draining a rewindable score FIFO.
// Revision : 1.0
// =============================================================================
module class_top2_select
    import class_sel_pkg::*;
#(
    parameter int unsigned SCORE_W       = 16,
    parameter int unsigned MAX_CLASSES   = 1000,
    parameter int unsigned RD_LAT        = 2,
    parameter int unsigned FLUSH_ON_DONE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    class_sel_if.slave bus
);
    localparam int unsigned IDX_W   = idx_width(MAX_CLASSES);
    localparam logic [15:0] c_max_n = 16'(MAX_CLASSES);
    localparam logic [7:0]  c_rd_lat = 8'(RD_LAT);

    logic [1:0]                rst_sync_q;
    logic                      w_rst_n;
    state_e                    state_q, state_d;
    logic [15:0]               n_q, n_d, issued_q, issued_d, ret_q, ret_d, w_n_req;
    logic [7:0]                wait_q, wait_d;
    logic [RD_LAT-1:0]         sr_q, sr_d;
    logic                      w_pop, w_mark, w_rrst, w_clear, w_latch, w_ret, w_start, w_excl;
    logic [IDX_W-1:0]          pass1_idx_q, am_idx;
    logic signed [SCORE_W-1:0] pass1_score_q, am_score;
    logic                      done_q, flush_q, busy_q, top2_vld_q;
    logic [IDX_W-1:0]          top1_idx_q, top2_idx_q;
    logic [SCORE_W-1:0]        top1_score_q, top2_score_q;

    // Reset asserts asynchronously and releases two clocks later, aligned to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign w_rst_n = rst_sync_q[1];

    assign w_n_req = (bus.i_num_classes > c_max_n) ? c_max_n : bus.i_num_classes;
    assign w_ret   = sr_q[RD_LAT-1];
    assign w_excl  = (state_q == S_PASS2) || (state_q == S_DRAIN2);

    generate
        if (RD_LAT == 1) begin : g_sr_single
            assign sr_d = w_pop;
        end else begin : g_sr_multi
            assign sr_d = {sr_q[RD_LAT-2:0], w_pop};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        issued_d = issued_q;
        ret_d    = w_ret ? (ret_q + 16'd1) : ret_q;
        wait_d   = wait_q;
        w_pop    = 1'b0;
        w_mark   = 1'b0;
        w_rrst   = 1'b0;
        w_clear  = 1'b0;
        w_latch  = 1'b0;
        w_start  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_start  = 1'b1;
                    w_clear  = 1'b1;
                    n_d      = w_n_req;
                    issued_d = '0;
                    ret_d    = '0;
                    state_d  = (w_n_req == 16'd0) ? S_DONE : S_MARK;
                end
            end
            S_MARK: begin
                w_mark  = 1'b1;
                state_d = S_PASS1;
            end
            S_PASS1, S_PASS2: begin
                w_pop = !bus.i_empty && (issued_q < n_q);
                if (w_pop) issued_d = issued_q + 16'd1;
                if (issued_q == n_q) state_d = (state_q == S_PASS1) ? S_DRAIN1 : S_DRAIN2;
            end
            S_DRAIN1: begin
                if (ret_q == n_q) begin
                    w_latch = 1'b1;
                    wait_d  = '0;
                    state_d = (n_q >= 16'd2) ? S_REWIND : S_DONE;
                end
            end
            S_REWIND: begin
                // Rewind pulse on the first cycle, then RD_LAT quiet cycles for the FIFO head to settle.
                wait_d = wait_q + 8'd1;
                if (wait_q == 8'd0) begin
                    w_rrst   = 1'b1;
                    w_clear  = 1'b1;
                    issued_d = '0;
                    ret_d    = '0;
                end
                if (wait_q == c_rd_lat) state_d = S_PASS2;
            end
            S_DRAIN2: begin
                if (ret_q == n_q) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            issued_q <= '0;
            ret_q    <= '0;
            wait_q   <= '0;
            sr_q     <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            issued_q <= issued_d;
            ret_q    <= ret_d;
            wait_q   <= wait_d;
            sr_q     <= sr_d;
        end
    end

    argmax_scan #(
        .SCORE_W (SCORE_W),
        .IDX_W   (IDX_W)
    ) u_argmax (
        .clk           (clk),
        .rst_n         (w_rst_n),
        .clear_i       (w_clear),
        .vld_i         (w_ret),
        .idx_i         (ret_q[IDX_W-1:0]),
        .score_i       ($signed(bus.i_front)),
        .exclude_en_i  (w_excl),
        .exclude_idx_i (pass1_idx_q),
        .best_idx_o    (am_idx),
        .best_score_o  (am_score)
    );

    // Published results move only in the DONE cycle; they stay put while a frame runs.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            done_q        <= 1'b0;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
            pass1_idx_q   <= '0;
            pass1_score_q <= '0;
            top1_idx_q    <= '0;
            top1_score_q  <= '0;
            top2_idx_q    <= '0;
            top2_score_q  <= '0;
            top2_vld_q    <= 1'b0;
        end else begin
            done_q  <= (state_q == S_DONE);
            flush_q <= (state_q == S_DONE) && (FLUSH_ON_DONE != 0);
            if (w_start) busy_q <= 1'b1;
            else if (state_q == S_DONE) busy_q <= 1'b0;
            if (w_latch) begin
                pass1_idx_q   <= am_idx;
                pass1_score_q <= am_score;
            end
            if (state_q == S_DONE) begin
                top1_idx_q   <= (n_q != 16'd0) ? pass1_idx_q : '0;
                top1_score_q <= (n_q != 16'd0) ? pass1_score_q : '0;
                top2_idx_q   <= (n_q >= 16'd2) ? am_idx : '0;
                top2_score_q <= (n_q >= 16'd2) ? am_score : '0;
                top2_vld_q   <= (n_q >= 16'd2);
            end
        end
    end

    assign bus.o_pop           = w_pop;
    assign bus.o_mark_read_rst = w_mark;
    assign bus.o_read_rst      = w_rrst;
    assign bus.o_flush         = flush_q;
    assign bus.o_busy          = busy_q;
    assign bus.o_done          = done_q;
    assign bus.o_top1_idx      = top1_idx_q;
    assign bus.o_top1_score    = top1_score_q;
    assign bus.o_top2_idx      = top2_idx_q;
    assign bus.o_top2_score    = top2_score_q;
    assign bus.o_top2_vld      = top2_vld_q;
endmodule
`default_nettype wire

// File: doc/class_top2_select.md
Name: class_top2_select

Overview:
- Consumer stage directly downstream of the per-class score FIFO. After a classification layer writes one score per class label, this block drains those scores and reports the best and second-best class index and score.
- Uses the FIFO's mark and read-rewind controls to make two passes over the same window: pass 1 finds top-1, pass 2 finds top-2 excluding the top-1 index.
- Optionally flushes the FIFO when the result is published.

Parameters:
- SCORE_W, 16, score width; scores are two's-complement signed.
- MAX_CLASSES, 1000, largest supported class count; IDX_W = $clog2(MAX_CLASSES).
- RD_LAT, 2, cycles from an accepted o_pop to the matching valid i_front.
- FLUSH_ON_DONE, 1, if 1 then o_flush pulses with o_done.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle request to begin a frame
- i_num_classes  in  16  number of scores in the frame; sampled on accepted start
- i_front  in  SCORE_W  FIFO head data
- i_empty  in  1  FIFO empty flag
- o_pop  out  1  FIFO pop request
- o_mark_read_rst  out  1  mark FIFO read pointer as the rewind point
- o_read_rst  out  1  rewind FIFO read pointer to the mark
- o_flush  out  1  empty the FIFO
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle result strobe
- o_top1_idx  out  IDX_W  index of best class
- o_top1_score  out  SCORE_W  best score
- o_top2_idx  out  IDX_W  index of second-best class
- o_top2_score  out  SCORE_W  second-best score
- o_top2_vld  out  1  top-2 result is meaningful

Behaviour:
- Reset (async assert, sync deassert inside block): all outputs 0; state IDLE.
- i_start is accepted only in IDLE. Start while busy is ignored.
- States and transitions:
  - IDLE: on start, latch N = i_num_classes, set o_busy. If N == 0, go to DONE. Otherwise go to MARK.
  - MARK: o_mark_read_rst high for exactly 1 cycle, then go to PASS1.
  - PASS1: o_pop = !i_empty && (issued < N). Pop issue stalls while the FIFO is empty. In-flight pops are tracked by an RD_LAT-deep valid shift register. When issued == N, go to DRAIN1.
  - DRAIN1: wait until all in-flight returns are consumed. Then go to REWIND if N ≥ 2, else go to DONE.
  - REWIND: o_read_rst high for 1 cycle, then wait RD_LAT cycles with no pops. Then go to PASS2 with counters cleared.
  - PASS2 / DRAIN2: same pop rules as pass 1. After the drain, go to DONE.
  - DONE: o_done high for 1 cycle. If FLUSH_ON_DONE, o_flush is high in the same cycle. Clear o_busy and go to IDLE.
- Each returned score carries an index equal to its return order within the pass (0..N-1); the returned-score counter wraps to 0 only at pass boundaries.
- Pass 1 update rule: replace best when score > best (signed, strict). Ties therefore keep the lowest index. The best score is initialised to the most negative value, and the first return always loads.
- Pass 2 uses the same rule but skips the element whose index equals top1_idx.
- Result outputs are updated in the DONE cycle and held until the next accepted start. They do not change during a frame.
- N == 0: o_done pulses 2 cycles after start with no pops. Results are 0 and o_top2_vld = 0.
- N == 1: single pass, no rewind. Top-1 is valid, o_top2_vld = 0, top2 fields are 0.
- N > MAX_CLASSES: clamp N to MAX_CLASSES.
- Asserting rst_n mid-frame aborts immediately. No o_done is produced; the FIFO state is the upstream owner's concern.
- No pop is issued in MARK, REWIND, DONE or IDLE. o_mark_read_rst, o_read_rst and o_pop are never high in the same cycle.
- Internal index and count arithmetic is 16-bit unsigned. Score compare is signed SCORE_W.

Decomposition:
- Shared package class_sel_pkg:
  - state enum (IDLE, MARK, PASS1, DRAIN1, REWIND, PASS2, DRAIN2, DONE)
  - SCORE_MIN constant
  - the IDX_W function
- One natural sub-module, argmax_scan: a streaming max tracker with inputs vld, idx, score, exclude_en and exclude_idx, and outputs best_idx and best_score, plus a clear input. It is instantiated once and cleared between passes.

Test Plan:
- N=4, scores {5,-3,9,2} preloaded, FIFO never empty → top1=(2,9), top2=(0,5), o_top2_vld=1, o_mark_read_rst once, o_read_rst once, exactly 8 pops, o_flush with o_done.
- N=5, scores {7,7,1,7,0} → ties: top1=(0,7), top2=(1,7).
- N=3, scores {-10,-2,-7} with i_empty forced high for 5 cycles mid-pass-1 → no pops while empty; result top1=(1,-2), top2=(2,-7).
- N=1, score {-32768} → top1=(0,-32768), o_top2_vld=0, no o_read_rst, 1 pop.
- N=0 → o_done 2 cycles after start, 0 pops, o_top2_vld=0; a second i_start during the frame is ignored (start count stays 1).
- rst_n low during PASS2 of an N=1000 frame → all outputs 0 asynchronously; no o_done; next start runs a clean frame with correct results.
